// File: rtl/nor_gate_pipe_pkg.sv
// Shared operation encodings and sizing constants for nor_gate_pipe.
package nor_gate_pipe_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOR  = 3'b000,
        OP_NAND = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

endpackage

// File: rtl/gate_reduce.sv
// Combinational bitwise reduction of N_IN operands, selected by op.
module gate_reduce
    import nor_gate_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_IN  = 2
) (
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  op_e                   op,
    output logic [WIDTH-1:0]      y_c
);

    logic [WIDTH-1:0] opnd0;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;

    // Fold all operands into AND/OR/XOR, then pick the requested function.
    always_comb begin
        opnd0 = in_data[WIDTH-1:0];
        and_r = opnd0;
        or_r  = opnd0;
        xor_r = opnd0;
        y_c   = '0;
        for (int unsigned k = 1; k < N_IN; k++) begin
            and_r = and_r & in_data[k*WIDTH +: WIDTH];
            or_r  = or_r  | in_data[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ in_data[k*WIDTH +: WIDTH];
        end
        case (op)
            OP_NOR:  y_c = ~or_r;
            OP_NAND: y_c = ~and_r;
            OP_AND:  y_c = and_r;
            OP_OR:   y_c = or_r;
            OP_XOR:  y_c = xor_r;
            OP_XNOR: y_c = ~xor_r;
            OP_NOT:  y_c = ~opnd0;
            OP_PASS: y_c = opnd0;
        endcase
    end

endmodule

// File: rtl/nor_gate_pipe.sv
// Two-stage valid/ready pipeline: S1 captures operands, S2 holds the reduced result.
module nor_gate_pipe
    import nor_gate_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_IN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]       op,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_W-1:0]    op_count
);

    localparam int unsigned DW = N_IN * WIDTH;

    logic             s1_valid;
    logic [DW-1:0]    s1_data;
    op_e              s1_op;
    logic [WIDTH-1:0] res_c;
    logic             s2_load_c;
    logic             accept_c;
    logic             consume_c;

    // Handshake: S2 takes S1 when empty or draining; S1 frees up as it advances.
    assign consume_c = out_valid && out_ready;
    assign s2_load_c = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load_c;
    assign accept_c  = in_valid && in_ready;

    gate_reduce #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_reduce (
        .in_data (s1_data),
        .op      (s1_op),
        .y_c     (res_c)
    );

    // S1: capture operands and op on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= OP_NOR;
        end else if (accept_c) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_op    <= op_e'(op);
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: register the result; hold it while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (s2_load_c) begin
            out_valid <= 1'b1;
            y         <= res_c;
        end else if (consume_c) begin
            out_valid <= 1'b0;
        end
    end

    // Count consumed results, wrapping naturally at the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (consume_c) begin
            op_count <= op_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nor_gate_pipe.sv
// Randomized and directed checks of nor_gate_pipe against a per-bit popcount model.
module tb_nor_gate_pipe;
    import nor_gate_pipe_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N_IN  = 3;
    localparam int unsigned DW    = N_IN * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    in_data;
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      op_count;

    always #5 clk = ~clk;

    nor_gate_pipe #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_count  (op_count)
    );

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [15:0]      exp_count = '0;
    logic             hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_y = '0;

    // Single comparison point: count it, report any mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: each result bit follows from how many operands have that bit set.
    function automatic logic [WIDTH-1:0] model(input logic [DW-1:0] d, input logic [2:0] o);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < int'(N_IN); k++) ones += int'(d[k*int'(WIDTH)+b]);
            case (o)
                OP_NOR:  r[b] = (ones == 0);
                OP_NAND: r[b] = (ones != int'(N_IN));
                OP_AND:  r[b] = (ones == int'(N_IN));
                OP_OR:   r[b] = (ones != 0);
                OP_XOR:  r[b] = (ones % 2 == 1);
                OP_XNOR: r[b] = (ones % 2 == 0);
                OP_NOT:  r[b] = !d[b];
                default: r[b] = d[b];
            endcase
        end
        return r;
    endfunction

    // One clock with scoreboard bookkeeping and protocol checks.
    task automatic cycle();
        @(negedge clk);
        if (hold_pend) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", 32'(y), 32'(hold_y));
        end
        hold_pend = out_valid && !out_ready;
        hold_y    = y;
        if (exp_q.size() == 2) begin
            check("full_valid", 32'(out_valid), 32'd1);
            if (!out_ready) check("full_stall_ready", 32'(in_ready), 32'd0);
        end
        if (exp_q.size() == 0) check("empty_ready", 32'(in_ready), 32'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check("y", 32'(y), 32'(exp_q.pop_front()));
                exp_count++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_data, op));
        @(posedge clk);
        #1;
        check("op_count", 32'(op_count), 32'(exp_count));
    endtask

    // Directed single operation on an empty pipeline, with latency checks.
    task automatic single(input string tag, input logic [DW-1:0] d, input logic [2:0] o,
                          input logic [WIDTH-1:0] want);
        in_data   = d;
        op        = o;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        op       = ~o;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_y"}, 32'(y), 32'(want));
        @(posedge clk);
        #1;
        exp_count++;
        check({tag, "_count"}, 32'(op_count), 32'(exp_count));
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int start;
        rst       = 1'b1;
        in_data   = '0;
        op        = 3'b000;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed function checks (operand 0 is the low byte).
        single("nor_a",  {8'h00, 8'h0F, 8'hF0}, OP_NOR,  8'h00);
        single("nor_b",  {8'h00, 8'h00, 8'h00}, OP_NOR,  8'hFF);
        single("xor",    {8'h01, 8'h0F, 8'hFF}, OP_XOR,  8'hF1);
        single("xnor",   {8'h01, 8'h0F, 8'hFF}, OP_XNOR, 8'h0E);
        single("and",    {8'hAA, 8'hCC, 8'hF0}, OP_AND,  8'h80);
        single("or",     {8'hAA, 8'hCC, 8'hF0}, OP_OR,   8'hFE);
        single("nand",   {8'hAA, 8'hCC, 8'hF0}, OP_NAND, 8'h7F);
        single("not",    {8'hAA, 8'hCC, 8'hF0}, OP_NOT,  8'h0F);
        single("pass",   {8'hAA, 8'hCC, 8'hF0}, OP_PASS, 8'hF0);

        // Back-to-back stream of 10 operations.
        start     = int'(exp_count);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) check("b2b_valid", 32'(out_valid), 32'd1);
            in_valid = (i < 10);
            in_data  = DW'($urandom);
            op       = 3'($urandom_range(0, 7));
            cycle();
        end
        check("b2b_count", 32'(int'(exp_count) - start), 32'd10);

        // Stall: only two operations fit, then drain in order.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'($urandom);
            op      = 3'($urandom_range(0, 7));
            cycle();
        end
        check("stall_accepted", 32'(exp_q.size()), 32'd2);
        check("stall_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            op        = 3'($urandom_range(0, 7));
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full, away from any clock edge.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (3) cycle();
        check("pre_rst_full", 32'(exp_q.size()), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_y", 32'(y), 32'd0);
        check("async_count", 32'(op_count), 32'd0);
        exp_q.delete();
        exp_count = '0;
        hold_pend = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("no_stale", 32'(out_valid), 32'd0);
            cycle();
        end

        // Counter wrap: stream until 16'hFFFF, then one more consumption.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = DW'(24'h123456);
        op        = OP_XOR;
        for (int i = 0; i < 70000 && op_count != 16'hFFFF; i++) begin
            @(posedge clk);
            #1;
        end
        check("wrap_reach", 32'(op_count), 32'hFFFF);
        check("wrap_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_zero", 32'(op_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
